cordic_lut_loader: RTL and testbench

Upstream stage for `cordic_hyp`: copies the 64-entry × 48-bit hyperbolic-CORDIC coefficient table from an external synchronous ROM into the core's LUT write port, then sequences the core's reset and releases it to run. It is the hardware replacement for the bench-driven write phase. It owns the core's `wen`, `index_wri`, `D` and `reset` pins. `fcw` and `offset` are wired to the core directly and are not handled here.

---
 rtl/cordic_lut_loader.sv | 118 +++++++++++
 tb/tb_cordic_lut_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cordic_lut_loader.sv
// Copies the hyperbolic-CORDIC coefficient table from an external sync ROM into the
// core's LUT write port, then sequences the core reset and releases the core to run.
module cordic_lut_loader #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 48,
  parameter int RST_CYC = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              wen_o,
  output logic [ADDR_W-1:0] index_wri_o,
  output logic [DATA_W-1:0] d_o,
  output logic              core_reset_o,
  output logic              run_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int FL_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(RST_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_WRITE = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              wen_q, wen_d;
  logic              core_reset_q, core_reset_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      fl_q         <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      wen_q        <= 1'b1;
      core_reset_q <= 1'b1;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fl_q         <= fl_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      wen_q        <= wen_d;
      core_reset_q <= core_reset_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // start wins over stop in RUN; start while loading is dropped, not queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_PRIME;
      S_PRIME: state_d = S_WRITE;
      S_WRITE: if (idx_q == IDX_LAST) state_d = S_FLUSH;
      S_FLUSH: if (fl_q == FL_LAST) state_d = S_RUN;
      S_RUN: begin
        if (start_i)     state_d = S_PRIME;
        else if (stop_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered with it;
  // the ROM read address runs one entry ahead of the write index.
  always_comb begin
    idx_d = idx_q;
    if (state_d == S_PRIME)
      idx_d = '0;
    else if (state_q == S_WRITE && state_d == S_WRITE)
      idx_d = idx_q + ADDR_W'(1);

    fl_d         = (state_q == S_FLUSH) ? fl_q + FL_W'(1) : '0;
    wen_d        = (state_d != S_WRITE);
    core_reset_d = (state_d == S_IDLE) || (state_d == S_PRIME) || (state_d == S_FLUSH);
    busy_d       = (state_d == S_PRIME) || (state_d == S_WRITE) || (state_d == S_FLUSH);
    run_d        = (state_d == S_RUN);
    done_d       = (state_q == S_FLUSH) && (state_d == S_RUN);
    rom_en_d     = (state_d == S_PRIME) || (state_d == S_WRITE && idx_d != IDX_LAST);
    rom_addr_d   = (state_d == S_WRITE && idx_d != IDX_LAST) ? idx_d + ADDR_W'(1) : '0;
  end

  assign rom_en_o     = rom_en_q;
  assign rom_addr_o   = rom_addr_q;
  assign wen_o        = wen_q;
  assign index_wri_o  = idx_q;
  assign d_o          = rom_data_i;
  assign core_reset_o = core_reset_q;
  assign run_o        = run_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_cordic_lut_loader.sv
// Directed bench for cordic_lut_loader: full-load timeline, ignored restarts,
// reload from RUN, stop / stop+start, and reset in the middle of a load.
module tb_cordic_lut_loader;

  localparam int AW = 6;
  localparam int DW = 48;
  localparam int RC = 2;
  localparam logic [DW-1:0] ROM_BASE = 48'h0000_0100_0000;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          wen;
  logic [AW-1:0] index_wri;
  logic [DW-1:0] d;
  logic          core_reset, run, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: ROM[k] = base + k, data one cycle after address/enable
  always @(posedge clk) if (rom_en) rom_data <= ROM_BASE + DW'(rom_addr);

  cordic_lut_loader #(.ADDR_W(AW), .DATA_W(DW), .RST_CYC(RC)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .wen_o(wen), .index_wri_o(index_wri), .d_o(d),
    .core_reset_o(core_reset), .run_o(run), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start (sampled at edge 0) and checks cycles 1..70 against the timeline.
  // r1/r2 are cycles during which start is re-asserted (0 = none).
  task automatic do_load(input string name, input int r1, input int r2);
    int wlow = 0;
    int bad  = 0;
    logic e_wen, e_busy, e_run, e_done, e_crst, e_en;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      e_wen  = !(c >= 2 && c <= 65);
      e_busy = (c <= 67);
      e_run  = (c >= 68);
      e_done = (c == 68);
      e_crst = (c == 1 || c == 66 || c == 67);
      e_en   = (c <= 64);
      chk($sformatf("%s wen@%0d", name, c), 64'(wen), 64'(e_wen));
      chk($sformatf("%s busy@%0d", name, c), 64'(busy), 64'(e_busy));
      chk($sformatf("%s run@%0d", name, c), 64'(run), 64'(e_run));
      chk($sformatf("%s done@%0d", name, c), 64'(done), 64'(e_done));
      chk($sformatf("%s core_reset@%0d", name, c), 64'(core_reset), 64'(e_crst));
      chk($sformatf("%s rom_en@%0d", name, c), 64'(rom_en), 64'(e_en));
      if (e_en)
        chk($sformatf("%s rom_addr@%0d", name, c), 64'(rom_addr), (c == 1) ? 64'd0 : 64'(c - 1));
      if (!e_wen) begin
        chk($sformatf("%s index_wri@%0d", name, c), 64'(index_wri), 64'(c - 2));
        chk($sformatf("%s D@%0d", name, c), 64'(d), 64'(ROM_BASE) + 64'(c - 2));
      end
      if (wen === 1'b0) wlow++;
      if (wen === 1'b0 && core_reset === 1'b1) bad++;
      start = (c == r1 || c == r2);
      step();
    end
    start = 1'b0;
    chk({name, " wen_low_count"}, 64'(wlow), 64'd64);
    chk({name, " write_with_core_reset"}, 64'(bad), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;

    // Reset values after the first edge with reset high
    step();
    chk("rst wen", 64'(wen), 64'd1);
    chk("rst core_reset", 64'(core_reset), 64'd1);
    chk("rst index_wri", 64'(index_wri), 64'd0);
    chk("rst rom_addr", 64'(rom_addr), 64'd0);
    chk("rst rom_en", 64'(rom_en), 64'd0);
    chk("rst run", 64'(run), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    step();
    reset = 1'b0;
    step();

    // stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle stop busy", 64'(busy), 64'd0);
    chk("idle stop core_reset", 64'(core_reset), 64'd1);

    do_load("basic", 0, 0);
    // From RUN: reload with ignored start pulses at cycles 10 and 66
    do_load("reload_restart", 10, 66);

    // stop alone in RUN -> IDLE
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop run", 64'(run), 64'd0);
    chk("stop core_reset", 64'(core_reset), 64'd1);
    chk("stop busy", 64'(busy), 64'd0);
    chk("stop wen", 64'(wen), 64'd1);
    step();
    chk("stop idle hold run", 64'(run), 64'd0);

    do_load("after_stop", 0, 0);

    // stop and start together in RUN -> PRIME
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk("stopstart busy", 64'(busy), 64'd1);
    chk("stopstart run", 64'(run), 64'd0);
    chk("stopstart rom_en", 64'(rom_en), 64'd1);
    chk("stopstart rom_addr", 64'(rom_addr), 64'd0);
    chk("stopstart core_reset", 64'(core_reset), 64'd1);
    step();
    chk("stopstart write wen", 64'(wen), 64'd0);
    chk("stopstart write index", 64'(index_wri), 64'd0);

    // Advance to cycle 30, reset for one cycle
    for (int c = 2; c < 30; c++) step();
    chk("midload wen low@30", 64'(wen), 64'd0);
    chk("midload index@30", 64'(index_wri), 64'd28);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst wen", 64'(wen), 64'd1);
    chk("midrst core_reset", 64'(core_reset), 64'd1);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst rom_en", 64'(rom_en), 64'd0);
    chk("midrst run", 64'(run), 64'd0);
    for (int c = 0; c < 5; c++) step();
    chk("midrst idle run", 64'(run), 64'd0);
    chk("midrst idle wen", 64'(wen), 64'd1);

    do_load("after_reset", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
